led_pattern_top: RTL and testbench

Board-level LED demo top for the iCE40-HX8K template. A free-running prescaler divides the system clock by 2^LOG2DELAY, and each prescaler tick advances two pattern generators: an 8-bit binary counter and a bouncing single-LED scanner. The `sel` board input picks which pattern drives the eight LED pins. Simulation benches shrink LOG2DELAY so patterns step quickly.

---
 rtl/led_pattern_top.sv | 116 +++++++++++
 tb/tb_led_pattern_top.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/led_pattern_top.sv
// led_pattern_top: board-level LED demo.
// A free-running prescaler produces a one-cycle tick every 2^LOG2DELAY clocks. Each tick advances
// an 8-bit binary counter and a bouncing single-LED scanner; both always run. A synchronized
// select input chooses which pattern is registered onto the eight LED pins.
//
// Parameters:
//   LOG2DELAY  prescaler width (1..30); one pattern step every 2^LOG2DELAY clocks
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   sel        asynchronous pattern select: 0 = binary counter, 1 = scanner
//   LED7..LED0 LED drives, 1 = lit, LED7 is the pattern MSB
module led_pattern_top #(
  parameter int unsigned LOG2DELAY = 22
) (
  input  logic clk,
  input  logic rst,
  input  logic sel,
  output logic LED7,
  output logic LED6,
  output logic LED5,
  output logic LED4,
  output logic LED3,
  output logic LED2,
  output logic LED1,
  output logic LED0
);

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_e;

  logic                 sel_s1_q, sel_s2_q;
  logic [LOG2DELAY-1:0] pre_q, pre_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [2:0]           pos_q, pos_d;
  dir_e                 dir_q, dir_d;
  logic [7:0]           led_q, led_d;
  logic                 tick;

  // True on the last cycle of each prescaler period.
  assign tick  = &pre_q;
  assign pre_d = pre_q + LOG2DELAY'(1);

  always_comb begin
    cnt_d = cnt_q;
    pos_d = pos_q;
    dir_d = dir_q;
    if (tick) begin
      cnt_d = cnt_q + 8'd1;
      unique case (dir_q)
        DirUp: begin
          if (pos_q == 3'd7) begin
            dir_d = DirDown;
            pos_d = 3'd6;
          end else begin
            pos_d = pos_q + 3'd1;
          end
        end
        DirDown: begin
          if (pos_q == 3'd0) begin
            dir_d = DirUp;
            pos_d = 3'd1;
          end else begin
            pos_d = pos_q - 3'd1;
          end
        end
        default: begin
          dir_d = DirUp;
          pos_d = 3'd0;
        end
      endcase
    end
  end

  // Output mux samples the current pattern state, so LEDs trail a pattern update by one clock.
  always_comb begin
    led_d = 8'h00;
    if (sel_s2_q) begin
      led_d = 8'd1 << pos_q;
    end else begin
      led_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_s1_q <= 1'b0;
      sel_s2_q <= 1'b0;
      pre_q    <= '0;
      cnt_q    <= 8'h00;
      pos_q    <= 3'd0;
      dir_q    <= DirUp;
      led_q    <= 8'h00;
    end else begin
      sel_s1_q <= sel;
      sel_s2_q <= sel_s1_q;
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      led_q    <= led_d;
    end
  end

  assign LED7 = led_q[7];
  assign LED6 = led_q[6];
  assign LED5 = led_q[5];
  assign LED4 = led_q[4];
  assign LED3 = led_q[3];
  assign LED2 = led_q[2];
  assign LED1 = led_q[1];
  assign LED0 = led_q[0];

endmodule

// File: tb/tb_led_pattern_top.sv
// Directed bench for led_pattern_top: one instance with LOG2DELAY = 8 for the main scenarios and
// one with LOG2DELAY = 1 for the short-period check. Edge numbers count rising edges after the
// last edge with reset high.
module tb_led_pattern_top;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic rst1 = 1'b1;
  logic sel1 = 1'b0;
  logic [7:0] leds, leds1;

  int n_assert = 0;
  int n_fail   = 0;
  int edge_k   = 0;

  always #5 clk = ~clk;

  led_pattern_top #(.LOG2DELAY(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .sel  (sel),
    .LED7 (leds[7]),
    .LED6 (leds[6]),
    .LED5 (leds[5]),
    .LED4 (leds[4]),
    .LED3 (leds[3]),
    .LED2 (leds[2]),
    .LED1 (leds[1]),
    .LED0 (leds[0])
  );

  led_pattern_top #(.LOG2DELAY(1)) dut1 (
    .clk  (clk),
    .rst  (rst1),
    .sel  (sel1),
    .LED7 (leds1[7]),
    .LED6 (leds1[6]),
    .LED5 (leds1[5]),
    .LED4 (leds1[4]),
    .LED3 (leds1[3]),
    .LED2 (leds1[2]),
    .LED1 (leds1[1]),
    .LED0 (leds1[0])
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance until edge number e has occurred, then settle 1 time unit past it.
  task automatic go(input int e);
    while (edge_k < e) begin
      @(posedge clk);
      edge_k++;
    end
    #1;
  endtask

  // Hold the L=8 instance in reset for 4 edges with the given select level.
  task automatic reset_main(input logic s);
    rst = 1'b1;
    sel = s;
    repeat (4) @(posedge clk);
    #1;
    check("reset_leds", leds, 8'h00);
    rst    = 1'b0;
    edge_k = 0;
  endtask

  // Scanner sequence as LED bytes, one entry per step.
  logic [7:0] scan_exp [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

  initial begin
    // Reset / idle and counter wrap
    reset_main(1'b0);
    go(1);     check("idle_e1",    leds, 8'h00);
    go(256);   check("idle_e256",  leds, 8'h00);
    go(257);   check("cnt_e257",   leds, 8'h01);
    go(512);   check("cnt_e512",   leds, 8'h01);
    go(513);   check("cnt_e513",   leds, 8'h02);
    go(255 * 256 + 1); check("cnt_ff_first", leds, 8'hFF);
    go(256 * 256);     check("cnt_ff_last",  leds, 8'hFF);
    go(256 * 256 + 1); check("cnt_wrap",     leds, 8'h00);

    // Scanner bounce
    reset_main(1'b1);
    go(3); check("scan_e3", leds, 8'h01);
    for (int m = 1; m < 16; m++) begin
      go(m * 256);     check($sformatf("scan_hold_%0d", m), leds, scan_exp[m-1]);
      go(m * 256 + 1); check($sformatf("scan_step_%0d", m), leds, scan_exp[m]);
    end

    // Live switch, then mid-run reset
    reset_main(1'b0);
    go(999);  sel = 1'b1;
    go(1001); check("sw_up_e1001",   leds, 8'h03);
    go(1002); check("sw_up_e1002",   leds, 8'h08);
    go(1999); sel = 1'b0;
    go(2001); check("sw_down_e2001", leds, 8'h80);
    go(2002); check("sw_down_e2002", leds, 8'h07);
    go(5000); check("pre_reset",     leds, 8'h13);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrun_reset", leds, 8'h00);
    rst    = 1'b0;
    edge_k = 0;
    go(256);  check("restart_e256", leds, 8'h00);
    go(257);  check("restart_e257", leds, 8'h01);

    // LOG2DELAY = 1: counter mode
    rst1 = 1'b1;
    sel1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("l1_reset", leds1, 8'h00);
    rst1   = 1'b0;
    edge_k = 0;
    go(2); check("l1_cnt_e2", leds1, 8'h00);
    go(3); check("l1_cnt_e3", leds1, 8'h01);
    go(4); check("l1_cnt_e4", leds1, 8'h01);
    go(5); check("l1_cnt_e5", leds1, 8'h02);
    go(7); check("l1_cnt_e7", leds1, 8'h03);

    // LOG2DELAY = 1: scanner, 28-cycle period
    rst1 = 1'b1;
    sel1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst1   = 1'b0;
    edge_k = 0;
    go(3);  check("l1_scan_e3",  leds1, 8'h02);
    go(15); check("l1_scan_e15", leds1, 8'h80);
    go(16); check("l1_scan_e16", leds1, 8'h80);
    go(17); check("l1_scan_e17", leds1, 8'h40);
    go(29); check("l1_scan_e29", leds1, 8'h01);
    go(31); check("l1_scan_e31", leds1, 8'h02);
    go(43); check("l1_scan_e43", leds1, 8'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
